dual_ram_be: RTL and testbench

//  True dual-port RAM, next generation of the sorting-path dual RAM. Adds per-port request/valid

---
 rtl/dual_ram_be_if.sv | 27 ++
 rtl/dual_ram_be.sv | 165 ++++++++++++++++
 tb/tb_dual_ram_be.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_ram_be_if.sv
// Per-port access bus of the byte-enable dual-port RAM: request, write
// qualifiers and the returned word with its valid strobe.
interface dual_ram_be_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int BWIDTH = 8
);
  localparam int NB = DWIDTH / BWIDTH;

  logic              req;
  logic              wr_en;
  logic [NB-1:0]     be;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wr_data;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_vld;

  modport master (
    output req, wr_en, be, addr, wr_data,
    input  rd_data, rd_vld
  );

  modport slave (
    input  req, wr_en, be, addr, wr_data,
    output rd_data, rd_vld
  );
endinterface

// File: rtl/dual_ram_be.sv
// True dual-port RAM with byte-enable writes, per-port return handshake,
// selectable read latency / read-during-write mode, cross-port write
// collision flag and a clear engine that fills memory with INIT_VALUE.
module dual_ram_be #(
  parameter int                DWIDTH     = 32,
  parameter int                AWIDTH     = 8,
  parameter int                NUM_WORDS  = 2**AWIDTH,
  parameter int                BWIDTH     = 8,
  parameter int                RD_LATENCY = 1,
  parameter int                RDW_MODE   = 0,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         coll_o,
  dual_ram_be_if.slave a_port,
  dual_ram_be_if.slave b_port
);
  localparam int NB = DWIDTH / BWIDTH;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;
  logic              done_d;

  logic [DWIDTH-1:0] mem [NUM_WORDS];

  // Index 0 is port A, index 1 is port B.
  logic [1:0]             acc, wr, in_rng, wr_ok;
  logic [1:0][NB-1:0]     be;
  logic [1:0][AWIDTH-1:0] addr;
  logic [1:0][DWIDTH-1:0] wd, old_w, new_w, ret_w;
  logic                   coll_now;

  logic [1:0]             vld_p1;
  logic [1:0][DWIDTH-1:0] rd_data_p1;

  function automatic logic [DWIDTH-1:0] merge_be(input logic [DWIDTH-1:0] old_word,
                                                 input logic [DWIDTH-1:0] wr_word,
                                                 input logic [NB-1:0]     lanes);
    logic [DWIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++)
      if (lanes[i]) res[i*BWIDTH +: BWIDTH] = wr_word[i*BWIDTH +: BWIDTH];
    return res;
  endfunction

  assign busy_o = (state_q == S_CLEAR);

  // Clear-engine state, pointer and completion pulse registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_o  <= done_d;
    end
  end

  // Clear-engine next state: sweep every word once, then return to idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_i) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        if (ptr_q == AWIDTH'(NUM_WORDS - 1)) begin
          state_d = S_IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + AWIDTH'(1);
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Port decode: acceptance, merged write words, collision arbitration and
  // the word each port gets back. Port A owns the word on a write collision,
  // so a write-first return on B shows A's merged word.
  always_comb begin
    acc  = {b_port.req, a_port.req} & {2{~busy_o & rst_ni}};
    wr   = {b_port.wr_en, a_port.wr_en};
    be   = {b_port.be, a_port.be};
    addr = {b_port.addr, a_port.addr};
    wd   = {b_port.wr_data, a_port.wr_data};
    for (int p = 0; p < 2; p++) begin
      in_rng[p] = {1'b0, addr[p]} < (AWIDTH+1)'(NUM_WORDS);
      old_w[p]  = in_rng[p] ? mem[addr[p]] : '0;
      new_w[p]  = merge_be(old_w[p], wd[p], be[p]);
    end
    coll_now = acc[0] & wr[0] & in_rng[0] & acc[1] & wr[1] & in_rng[1] &
               (addr[0] == addr[1]);
    wr_ok[0] = acc[0] & wr[0] & in_rng[0];
    wr_ok[1] = acc[1] & wr[1] & in_rng[1] & ~coll_now;
    ret_w[0] = (wr[0] && RDW_MODE == 0) ? new_w[0] : old_w[0];
    ret_w[1] = (wr[1] && RDW_MODE == 0) ? (coll_now ? new_w[0] : new_w[1]) : old_w[1];
    for (int p = 0; p < 2; p++)
      if (!in_rng[p]) ret_w[p] = '0;
  end

  // Memory array: clear-engine fill plus the two port writes.
  always_ff @(posedge clk_i) begin
    if (busy_o && rst_ni) mem[ptr_q] <= INIT_VALUE;
    for (int p = 0; p < 2; p++)
      if (wr_ok[p]) mem[addr[p]] <= new_w[p];
  end

  // ---- stage p1: return word captured on acceptance, held between valids
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1     <= '0;
      rd_data_p1 <= '0;
      coll_o     <= 1'b0;
    end else begin
      vld_p1 <= acc;
      coll_o <= coll_now;
      for (int p = 0; p < 2; p++)
        if (acc[p]) rd_data_p1[p] <= ret_w[p];
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [1:0]             vld_p2;
      logic [1:0][DWIDTH-1:0] rd_data_p2;

      // ---- stage p2: optional output register
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          vld_p2     <= '0;
          rd_data_p2 <= '0;
        end else begin
          vld_p2 <= vld_p1;
          for (int p = 0; p < 2; p++)
            if (vld_p1[p]) rd_data_p2[p] <= rd_data_p1[p];
        end
      end

      assign a_port.rd_vld  = vld_p2[0];
      assign a_port.rd_data = rd_data_p2[0];
      assign b_port.rd_vld  = vld_p2[1];
      assign b_port.rd_data = rd_data_p2[1];
    end else begin : g_lat1
      assign a_port.rd_vld  = vld_p1[0];
      assign a_port.rd_data = rd_data_p1[0];
      assign b_port.rd_vld  = vld_p1[1];
      assign b_port.rd_data = rd_data_p1[1];
    end
  endgenerate
endmodule

// File: tb/tb_dual_ram_be.sv
// Bench for dual_ram_be: two instances (full-size write-first latency 1, and
// 200-word read-first latency 2) driven with the same stimulus and compared
// every cycle against a word-level reference model.
module tb_dual_ram_be;
  localparam logic [31:0] INIT = 32'hA5A5A5A5;
  localparam int NW  [2] = '{256, 200};
  localparam int LAT [2] = '{1, 2};
  localparam int MODE[2] = '{0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr;
  logic [1:0]  r_req, r_wr;
  logic [3:0]  r_be   [2];
  logic [7:0]  r_addr [2];
  logic [31:0] r_wd   [2];
  logic [1:0]  busy, done, coll;
  logic [1:0]  obs_vld [2];
  logic [31:0] obs_d   [2][2];

  dual_ram_be_if #(.DWIDTH(32), .AWIDTH(8), .BWIDTH(8)) ia0 ();
  dual_ram_be_if #(.DWIDTH(32), .AWIDTH(8), .BWIDTH(8)) ib0 ();
  dual_ram_be_if #(.DWIDTH(32), .AWIDTH(8), .BWIDTH(8)) ia1 ();
  dual_ram_be_if #(.DWIDTH(32), .AWIDTH(8), .BWIDTH(8)) ib1 ();

  assign ia0.req = r_req[0]; assign ia0.wr_en = r_wr[0]; assign ia0.be = r_be[0];
  assign ia0.addr = r_addr[0]; assign ia0.wr_data = r_wd[0];
  assign ib0.req = r_req[1]; assign ib0.wr_en = r_wr[1]; assign ib0.be = r_be[1];
  assign ib0.addr = r_addr[1]; assign ib0.wr_data = r_wd[1];
  assign ia1.req = r_req[0]; assign ia1.wr_en = r_wr[0]; assign ia1.be = r_be[0];
  assign ia1.addr = r_addr[0]; assign ia1.wr_data = r_wd[0];
  assign ib1.req = r_req[1]; assign ib1.wr_en = r_wr[1]; assign ib1.be = r_be[1];
  assign ib1.addr = r_addr[1]; assign ib1.wr_data = r_wd[1];

  assign obs_vld[0] = {ib0.rd_vld, ia0.rd_vld};
  assign obs_vld[1] = {ib1.rd_vld, ia1.rd_vld};
  assign obs_d[0][0] = ia0.rd_data; assign obs_d[0][1] = ib0.rd_data;
  assign obs_d[1][0] = ia1.rd_data; assign obs_d[1][1] = ib1.rd_data;

  dual_ram_be #(.DWIDTH(32), .AWIDTH(8), .NUM_WORDS(256), .BWIDTH(8),
                .RD_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(INIT)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy[0]), .done_o(done[0]),
    .coll_o(coll[0]), .a_port(ia0), .b_port(ib0));

  dual_ram_be #(.DWIDTH(32), .AWIDTH(8), .NUM_WORDS(200), .BWIDTH(8),
                .RD_LATENCY(2), .RDW_MODE(1), .INIT_VALUE(INIT)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy[1]), .done_o(done[1]),
    .coll_o(coll[1]), .a_port(ia1), .b_port(ib1));

  // Reference model state.
  logic [31:0] mem_m [2][256];
  bit          m_busy [2];
  int          m_ptr  [2];
  bit          e_done [2], e_coll [2];
  bit          e_vld  [2][2];
  logic [31:0] e_hold [2][2];
  bit          ev_v   [2][2][4];   // returns indexed by acceptance cycle mod 4
  logic [31:0] ev_d   [2][2][4];
  int          acc_cnt[2][2], vld_cnt[2][2];
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  int          done_seen;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] lanes);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (lanes[k]) m |= (32'hFF << (8*k));
    return (o & ~m) | (n & m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the model, using the inputs the DUTs just sampled.
  task automatic model_edge();
    int slot, src;
    bit inr[2], wa, wb, hit;
    logic [31:0] pre[2], ret;
    cyc++;
    slot = cyc % 4;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) ev_v[i][p][slot] = 0;
      e_done[i] = 0;
      e_coll[i] = 0;
      if (!rst_n) begin
        m_busy[i] = 1; m_ptr[i] = 0;
        for (int p = 0; p < 2; p++) begin
          e_vld[i][p] = 0; e_hold[i][p] = '0;
          for (int k = 0; k < 4; k++) ev_v[i][p][k] = 0;
        end
        continue;
      end
      if (m_busy[i]) begin
        mem_m[i][m_ptr[i]] = INIT;
        m_ptr[i]++;
        if (m_ptr[i] == NW[i]) begin m_busy[i] = 0; e_done[i] = 1; end
      end else begin
        for (int p = 0; p < 2; p++) begin
          inr[p] = int'(r_addr[p]) < NW[i];
          pre[p] = inr[p] ? mem_m[i][r_addr[p]] : 32'h0;
        end
        wa  = r_req[0] && r_wr[0] && inr[0];
        wb  = r_req[1] && r_wr[1] && inr[1];
        hit = wa && wb && (r_addr[0] == r_addr[1]);
        if (wa) mem_m[i][r_addr[0]] = bmerge(pre[0], r_wd[0], r_be[0]);
        if (wb && !hit) mem_m[i][r_addr[1]] = bmerge(pre[1], r_wd[1], r_be[1]);
        e_coll[i] = hit;
        for (int p = 0; p < 2; p++) begin
          if (!r_req[p]) continue;
          // write-first sees the word memory holds after this edge
          if (!inr[p])                   ret = '0;
          else if (r_wr[p] && MODE[i] == 0) ret = mem_m[i][r_addr[p]];
          else                           ret = pre[p];
          ev_v[i][p][slot] = 1;
          ev_d[i][p][slot] = ret;
          acc_cnt[i][p]++;
        end
        if (clr) begin m_busy[i] = 1; m_ptr[i] = 0; end
      end
      src = (cyc - LAT[i] + 1) % 4;
      for (int p = 0; p < 2; p++) begin
        e_vld[i][p] = ev_v[i][p][src];
        if (e_vld[i][p]) e_hold[i][p] = ev_d[i][p][src];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_busy[i]));
      chk($sformatf("done%0d", i), 32'(done[i]), 32'(e_done[i]));
      chk($sformatf("coll%0d", i), 32'(coll[i]), 32'(e_coll[i]));
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("vld%0d_%0d", i, p), 32'(obs_vld[i][p]), 32'(e_vld[i][p]));
        chk($sformatf("data%0d_%0d", i, p), obs_d[i][p], e_hold[i][p]);
        if (obs_vld[i][p]) vld_cnt[i][p]++;
      end
    end
    if (done[0]) done_seen++;
  endtask

  task automatic idle();
    r_req = '0; r_wr = '0;
    for (int p = 0; p < 2; p++) begin r_be[p] = '0; r_addr[p] = '0; r_wd[p] = '0; end
  endtask

  task automatic acc_in(input int p, input bit w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] lanes);
    r_req[p] = 1'b1; r_wr[p] = w; r_addr[p] = a; r_wd[p] = d; r_be[p] = lanes;
  endtask

  task automatic rand_in();
    for (int p = 0; p < 2; p++) begin
      r_req[p]  = ($urandom_range(0, 9) < 7);
      r_wr[p]   = $urandom_range(0, 1) == 1;
      r_be[p]   = 4'($urandom);
      r_addr[p] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255))
                                               : 8'($urandom_range(0, 15));
      r_wd[p]   = $urandom;
    end
  endtask

  task automatic wait_clear(input bit random_req);
    for (int k = 0; k < 400 && (m_busy[0] || m_busy[1]); k++) begin
      if (random_req) rand_in();
      tick();
    end
    chk("clear_timeout", 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; idle();
    done_seen = 0;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin acc_cnt[i][p] = 0; vld_cnt[i][p] = 0; end

    // Reset, then power-up clear; every address reads back INIT.
    tick(); tick();
    rst_n = 1'b1;
    wait_clear(1'b0);
    chk("done_after_reset", 32'(done_seen), 32'd1);
    for (int k = 0; k < 256; k++) begin
      acc_in(0, 0, 8'(k), '0, '0);
      acc_in(1, 0, 8'(255 - k), '0, '0);
      tick();
    end
    idle(); tick(); tick();

    // Byte-enable write over INIT, then read back.
    acc_in(0, 1, 8'd3, 32'h11223344, 4'b0101); tick();
    acc_in(0, 0, 8'd3, '0, '0); tick();
    chk("be_rd_lat1", obs_d[0][0], 32'hA522A544);
    idle(); tick();
    chk("be_rd_lat2", obs_d[1][0], 32'hA522A544);

    // Both ports write addr 7 in the same cycle.
    acc_in(0, 1, 8'd7, 32'hDEAD0001, 4'hF);
    acc_in(1, 1, 8'd7, 32'hBEEF0002, 4'hF); tick();
    chk("coll_pulse", 32'(coll), 32'h3);
    chk("coll_b_ret_wf", obs_d[0][1], 32'hDEAD0001);
    idle(); acc_in(1, 0, 8'd7, '0, '0); tick();
    chk("coll_clear", 32'(coll), 32'h0);
    chk("coll_b_ret_rf", obs_d[1][1], 32'hA5A5A5A5);
    idle(); tick();
    chk("coll_word", obs_d[1][1], 32'hDEAD0001);

    // A writes addr 9 while B reads it.
    acc_in(0, 1, 8'd9, 32'h12345678, 4'hF);
    acc_in(1, 0, 8'd9, '0, '0); tick();
    chk("rdw_a_wf", obs_d[0][0], 32'h12345678);
    chk("rdw_b_old0", obs_d[0][1], 32'hA5A5A5A5);
    idle(); tick();
    chk("rdw_a_rf", obs_d[1][0], 32'hA5A5A5A5);
    chk("rdw_b_old1", obs_d[1][1], 32'hA5A5A5A5);

    // Empty-lane write, shared read, and out-of-range accesses.
    acc_in(0, 1, 8'd5, 32'hFFFFFFFF, 4'h0); acc_in(1, 0, 8'd5, '0, '0); tick();
    acc_in(0, 0, 8'd5, '0, '0); acc_in(1, 0, 8'd5, '0, '0); tick();
    acc_in(0, 1, 8'd220, 32'h0BADF00D, 4'hF); acc_in(1, 0, 8'd220, '0, '0); tick();
    acc_in(0, 0, 8'd220, '0, '0); idle(); acc_in(0, 0, 8'd220, '0, '0); tick();
    idle(); tick(); tick();

    // Clear on request, reset at clear cycle 100, requests while busy.
    done_seen = 0;
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      rand_in(); clr = $urandom_range(0, 1) == 1; tick();
    end
    clr = 1'b0;
    rst_n = 1'b0; rand_in(); tick(); rst_n = 1'b1;
    wait_clear(1'b1);
    idle(); tick();
    chk("single_done", 32'(done_seen), 32'd1);

    // Random traffic against the model.
    for (int k = 0; k < 10000; k++) begin
      rand_in();
      clr = ($urandom_range(0, 999) == 0);
      tick();
    end
    clr = 1'b0; idle();
    for (int k = 0; k < 4; k++) tick();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++)
        chk($sformatf("vld_count%0d_%0d", i, p), 32'(vld_cnt[i][p]), 32'(acc_cnt[i][p]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
